conv3x3_pipe: RTL and testbench

- Streaming 3x3 neighbourhood filter. Sits directly downstream of the 4-line buffer stage.
- Each valid beat delivers one 72-bit window of nine 8-bit pixels. The block emits one 8-bit filtered pixel per window after a fixed 3-cycle pipeline.
- Counts output pixels and lines. Raises end-of-line and end-of-frame pulses for the DMA/interrupt stage that follows.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/sat_clamp.sv | 24 ++
 rtl/conv3x3_pipe.sv | 189 ++++++++++++++++++
 tb/tb_conv3x3_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// ============================================================================
// Module : conv_pkg
// Shared constants, filter-mode encoding and window unpack helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int WIN_W = 72;
    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_GAUSS = 2'd1,
        MODE_SOBEL = 2'd2,
        MODE_SHARP = 2'd3
    } mode_t;

    // Pixel w(r,c) sits at bits [24r+8c+7 : 24r+8c]; row 0 is the oldest line.
    function automatic logic [PIX_W-1:0] win_pix(input logic [WIN_W-1:0] win,
                                                 input int r, input int c);
        return win[24*r + 8*c +: PIX_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_clamp.sv
// ============================================================================
// Module : sat_clamp
// Clamps a signed 13-bit value to the unsigned pixel range 0..255.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sat_clamp (
    input  logic signed [12:0] value,
    output logic        [7:0]  clamped
);

    always_comb begin
        clamped = value[7:0];
        if (value < 13'sd0) begin
            clamped = 8'd0;
        end else if (value > 13'sd255) begin
            clamped = 8'd255;
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv3x3_pipe.sv
// ============================================================================
// Module : conv3x3_pipe
// Three-stage streaming 3x3 filter (pass/gauss/sobel/sharpen) with line/frame
// position counters and end-of-line / end-of-frame pulses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module conv3x3_pipe
    import conv_pkg::*;
#(
    parameter int LINE_WIDTH  = 256,
    parameter int OUT_LINES   = 254,
    parameter int SOBEL_SHIFT = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIN_W-1:0] i_window,
    input  logic             i_window_valid,
    input  logic [1:0]       i_mode,
    output logic [PIX_W-1:0] o_pixel,
    output logic             o_pixel_valid,
    output logic             o_eol,
    output logic             o_eof,
    output logic             o_busy
);

    localparam int PIX_CNT_W  = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int LINE_CNT_W = (OUT_LINES  > 1) ? $clog2(OUT_LINES)  : 1;

    // ---------------- S1: row / column partial sums ----------------
    logic [7:0]  w [3][3];
    logic [9:0]  row_sum [3];
    logic [9:0]  col0_sum, col2_sum, cross_sum;
    logic [10:0] ctr5;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w[r][c] = win_pix(i_window, r, c);
            end
        end
        // Row sums double as the Gy terms: Gy = row2 - row0.
        for (int r = 0; r < 3; r++) begin
            row_sum[r] = {2'b00, w[r][0]} + {1'b0, w[r][1], 1'b0} + {2'b00, w[r][2]};
        end
        col0_sum  = {2'b00, w[0][0]} + {1'b0, w[1][0], 1'b0} + {2'b00, w[2][0]};
        col2_sum  = {2'b00, w[0][2]} + {1'b0, w[1][2], 1'b0} + {2'b00, w[2][2]};
        cross_sum = {2'b00, w[0][1]} + {2'b00, w[1][0]} + {2'b00, w[1][2]} + {2'b00, w[2][1]};
        ctr5      = {1'b0, w[1][1], 2'b00} + {3'b000, w[1][1]};
    end

    logic        s1_valid;
    mode_t       s1_mode;
    logic [7:0]  s1_center;
    logic [9:0]  s1_row0, s1_row1, s1_row2, s1_col0, s1_col2, s1_cross;
    logic [10:0] s1_ctr5;

    // ---------------- S2: signed sums and magnitudes ----------------
    logic        [11:0] gauss_sum;
    logic signed [10:0] gx, gy;
    logic        [10:0] gx_abs, gy_abs;
    logic        [11:0] mag_sum;
    logic signed [11:0] sharp_diff;

    always_comb begin
        gauss_sum  = {2'b00, s1_row0} + {1'b0, s1_row1, 1'b0} + {2'b00, s1_row2};
        gx         = $signed({1'b0, s1_col2}) - $signed({1'b0, s1_col0});
        gy         = $signed({1'b0, s1_row2}) - $signed({1'b0, s1_row0});
        gx_abs     = gx[10] ? $unsigned(-gx) : $unsigned(gx);
        gy_abs     = gy[10] ? $unsigned(-gy) : $unsigned(gy);
        mag_sum    = {1'b0, gx_abs} + {1'b0, gy_abs};
        sharp_diff = $signed({1'b0, s1_ctr5}) - $signed({2'b00, s1_cross});
    end

    logic               s2_valid;
    mode_t              s2_mode;
    logic        [7:0]  s2_center;
    logic        [11:0] s2_gauss, s2_mag;
    logic signed [11:0] s2_sharp;

    // ---------------- S3: shift, clamp, mode mux ----------------
    logic        [11:0] mag_shifted;
    logic signed [12:0] sobel_in, sharp_in;
    logic        [7:0]  sobel_pix, sharp_pix;
    logic        [7:0]  next_pixel;

    always_comb begin
        mag_shifted = s2_mag >> SOBEL_SHIFT;
        sobel_in    = $signed({1'b0, mag_shifted});
        sharp_in    = $signed({s2_sharp[11], s2_sharp});
    end

    sat_clamp u_sobel_clamp (
        .value   (sobel_in),
        .clamped (sobel_pix)
    );

    sat_clamp u_sharp_clamp (
        .value   (sharp_in),
        .clamped (sharp_pix)
    );

    always_comb begin
        next_pixel = s2_center;
        case (s2_mode)
            MODE_PASS:  next_pixel = s2_center;
            MODE_GAUSS: next_pixel = s2_gauss[11:4];
            MODE_SOBEL: next_pixel = sobel_pix;
            MODE_SHARP: next_pixel = sharp_pix;
            default:    next_pixel = s2_center;
        endcase
    end

    // Position counters track the pixel entering the output register, so the
    // pulses land in the same cycle as that pixel.
    logic [PIX_CNT_W-1:0]  pix_cnt;
    logic [LINE_CNT_W-1:0] line_cnt;
    logic                  last_pix, last_line;

    always_comb begin
        last_pix  = (pix_cnt  == PIX_CNT_W'(LINE_WIDTH - 1));
        last_line = (line_cnt == LINE_CNT_W'(OUT_LINES - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid      <= 1'b0;
            s1_mode       <= MODE_PASS;
            s1_center     <= '0;
            s1_row0       <= '0;
            s1_row1       <= '0;
            s1_row2       <= '0;
            s1_col0       <= '0;
            s1_col2       <= '0;
            s1_cross      <= '0;
            s1_ctr5       <= '0;
            s2_valid      <= 1'b0;
            s2_mode       <= MODE_PASS;
            s2_center     <= '0;
            s2_gauss      <= '0;
            s2_mag        <= '0;
            s2_sharp      <= '0;
            o_pixel       <= '0;
            o_pixel_valid <= 1'b0;
            o_eol         <= 1'b0;
            o_eof         <= 1'b0;
            pix_cnt       <= '0;
            line_cnt      <= '0;
        end else begin
            s1_valid      <= i_window_valid;
            s1_mode       <= mode_t'(i_mode);
            s1_center     <= w[1][1];
            s1_row0       <= row_sum[0];
            s1_row1       <= row_sum[1];
            s1_row2       <= row_sum[2];
            s1_col0       <= col0_sum;
            s1_col2       <= col2_sum;
            s1_cross      <= cross_sum;
            s1_ctr5       <= ctr5;

            s2_valid      <= s1_valid;
            s2_mode       <= s1_mode;
            s2_center     <= s1_center;
            s2_gauss      <= gauss_sum;
            s2_mag        <= mag_sum;
            s2_sharp      <= sharp_diff;

            o_pixel       <= next_pixel;
            o_pixel_valid <= s2_valid;
            o_eol         <= s2_valid && last_pix;
            o_eof         <= s2_valid && last_pix && last_line;

            if (s2_valid) begin
                if (last_pix) begin
                    pix_cnt  <= '0;
                    line_cnt <= last_line ? '0 : line_cnt + 1'b1;
                end else begin
                    pix_cnt  <= pix_cnt + 1'b1;
                end
            end
        end
    end

    assign o_busy = s1_valid | s2_valid | o_pixel_valid;

endmodule

`default_nettype wire

// File: tb/tb_conv3x3_pipe.sv
// ============================================================================
// Module : tb_conv3x3_pipe
// Scoreboard bench for conv3x3_pipe: directed windows, mode interleave,
// mid-flight reset and a full randomly-gapped frame.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_conv3x3_pipe;

    localparam int LW = 256;
    localparam int OL = 254;
    localparam int SH = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [71:0] window = '0;
    logic        window_valid = 1'b0;
    logic [1:0]  mode = '0;
    logic [7:0]  pixel;
    logic        pixel_valid, eol, eof, busy;

    always #5 clk = ~clk;

    conv3x3_pipe #(.LINE_WIDTH(LW), .OUT_LINES(OL), .SOBEL_SHIFT(SH)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_window       (window),
        .i_window_valid (window_valid),
        .i_mode         (mode),
        .o_pixel        (pixel),
        .o_pixel_valid  (pixel_valid),
        .o_eol          (eol),
        .o_eof          (eof),
        .o_busy         (busy)
    );

    typedef struct {
        int pix;
        int eol;
        int eof;
        int issue;
    } exp_t;

    exp_t     sb[$];
    int       n_checks = 0, n_fail = 0, cyc = 0;
    int       m_pix = 0, m_line = 0;
    logic [2:0] hist = '0;
    int       eol_cnt = 0, eof_cnt = 0, out_since_rst = 0, first_eol_idx = 0;
    int       last_eol_had_eof = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int ref_pix(input logic [71:0] win, input logic [1:0] m);
        int p[3][3];
        int gx, gy, mag, s;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[r][c] = int'(win[24*r + 8*c +: 8]);
        case (m)
            2'd0: return p[1][1];
            2'd1: return (p[0][0] + 2*p[0][1] + p[0][2] + 2*p[1][0] + 4*p[1][1]
                          + 2*p[1][2] + p[2][0] + 2*p[2][1] + p[2][2]) >> 4;
            2'd2: begin
                gx  = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
                gy  = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
                mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
                mag = mag >> SH;
                return (mag > 255) ? 255 : mag;
            end
            default: begin
                s = 5*p[1][1] - (p[0][1] + p[1][0] + p[1][2] + p[2][1]);
                return (s < 0) ? 0 : ((s > 255) ? 255 : s);
            end
        endcase
    endfunction

    function automatic logic [71:0] mk_cols(input logic [7:0] c0, input logic [7:0] c1,
                                            input logic [7:0] c2);
        logic [71:0] v;
        for (int r = 0; r < 3; r++) begin
            v[24*r +: 8]      = c0;
            v[24*r + 8 +: 8]  = c1;
            v[24*r + 16 +: 8] = c2;
        end
        return v;
    endfunction

    function automatic logic [71:0] mk_centre(input logic [7:0] ctr, input logic [7:0] oth);
        logic [71:0] v;
        v = mk_cols(oth, oth, oth);
        v[32 +: 8] = ctr;
        return v;
    endfunction

    task automatic monitor();
        exp_t e;
        check_eq("busy", busy, (hist != 3'b000));
        if (pixel_valid === 1'b1) begin
            out_since_rst++;
            if (eol === 1'b1) begin
                eol_cnt++;
                last_eol_had_eof = (eof === 1'b1);
                if (first_eol_idx == 0) first_eol_idx = out_since_rst;
            end
            if (eof === 1'b1) eof_cnt++;
            if (sb.size() == 0) begin
                check_eq("unexpected_output", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("pixel", pixel, e.pix);
                check_eq("eol", eol, e.eol);
                check_eq("eof", eof, e.eof);
                check_eq("latency", cyc - e.issue, 3);
            end
        end else begin
            check_eq("eol_idle", eol, 0);
            check_eq("eof_idle", eof, 0);
        end
    endtask

    // One cycle: sample outputs at the falling edge, then drive the next inputs.
    task automatic drive(input logic v, input logic [71:0] w, input logic [1:0] m,
                         input logic r = 1'b0, input int xp = -1);
        exp_t e;
        @(negedge clk);
        cyc++;
        monitor();
        rst          = r;
        window_valid = v;
        window       = w;
        mode         = m;
        if (r) begin
            sb.delete();
            hist = '0;
            m_pix = 0; m_line = 0;
            out_since_rst = 0; first_eol_idx = 0;
            eol_cnt = 0; eof_cnt = 0;
        end else begin
            hist = {hist[1:0], v};
            if (v) begin
                e.pix   = (xp >= 0) ? xp : ref_pix(w, m);
                e.eol   = (m_pix == LW - 1) ? 1 : 0;
                e.eof   = (e.eol == 1 && m_line == OL - 1) ? 1 : 0;
                e.issue = cyc;
                sb.push_back(e);
                if (m_pix == LW - 1) begin
                    m_pix  = 0;
                    m_line = (m_line == OL - 1) ? 0 : m_line + 1;
                end else begin
                    m_pix++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0, 2'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && sb.size() != 0; k++) idle(1);
        check_eq("drain_empty", sb.size(), 0);
    endtask

    function automatic logic [71:0] rand_win();
        return {8'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    initial begin
        // Reset state
        for (int k = 0; k < 3; k++) drive(1'b0, '0, 2'd0, 1'b1);
        check_eq("rst_pixel", pixel, 0);
        check_eq("rst_valid", pixel_valid, 0);
        check_eq("rst_eol", eol, 0);
        check_eq("rst_eof", eof, 0);
        check_eq("rst_busy", busy, 0);
        idle(2);

        // Uniform window through every mode, back to back
        for (int m = 0; m < 4; m++)
            drive(1'b1, mk_centre(8'd100, 8'd100), 2'(m), 1'b0, (m == 2) ? 0 : 100);
        idle(4);

        // Edge / saturation cases
        drive(1'b1, mk_cols(8'd0, 8'd255, 8'd255), 2'd2, 1'b0, 255);
        drive(1'b1, mk_centre(8'd0, 8'd255), 2'd3, 1'b0, 0);
        drive(1'b1, mk_centre(8'd255, 8'd0), 2'd3, 1'b0, 255);
        drive(1'b1, mk_cols(8'd0, 8'd255, 8'd255), 2'd1, 1'b0);
        idle(1);
        drive(1'b1, mk_cols(8'd255, 8'd0, 8'd0), 2'd2, 1'b0, 255);
        drain();

        // Mode rotates every beat on a continuous random stream
        for (int k = 0; k < 64; k++) drive(1'b1, rand_win(), 2'(k % 4));
        drain();

        // Reset with three beats in flight
        for (int k = 0; k < 3; k++) drive(1'b1, rand_win(), 2'(k));
        drive(1'b0, '0, 2'd0, 1'b1);
        drive(1'b0, '0, 2'd0);
        check_eq("flight_rst_valid", pixel_valid, 0);
        check_eq("flight_rst_busy", busy, 0);
        check_eq("flight_rst_eol", eol, 0);

        // Full frame with random gaps
        for (int i = 0; i < LW * OL; i++) begin
            if ($urandom_range(0, 7) == 0) idle(1);
            drive(1'b1, rand_win(), 2'($urandom_range(0, 3)));
        end
        drain();
        check_eq("frame_eol_count", eol_cnt, OL);
        check_eq("frame_eof_count", eof_cnt, 1);
        check_eq("first_eol_index", first_eol_idx, LW);
        check_eq("eof_on_final_eol", last_eol_had_eof, 1);

        // Next frame starts cleanly after the frame end
        for (int k = 0; k < 8; k++) drive(1'b1, rand_win(), 2'(k % 4));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
